// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: recovers pixel coordinates from an active-low
// hSync/vSync pair, verifies every sync edge against nominal timing and reports lock.
module vga_sync_decoder #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk25175KHz,
    input  logic       reset_n,
    input  logic       hSync,
    input  logic       vSync,
    output logic       locked,
    output logic       de,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       frame_start,
    output logic       sync_err,
    output logic [1:0] err_code
);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DE_FIRST  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_DE_END    = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_DE_FIRST  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_DE_END    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] CNT_MAX     = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic       hs_prev, vs_prev;
    logic       hfall, hrise, vfall, vrise, frame_edge;
    logic [3:0] err_vec;
    logic       err_any;
    logic [1:0] code_nxt;
    logic       locked_nxt, de_nxt, frame_start_nxt;
    logic [9:0] px_x_nxt, px_y_nxt;

    assign hfall      = hs_prev & ~hSync;
    assign hrise      = ~hs_prev & hSync;
    assign vfall      = vs_prev & ~vSync;
    assign vrise      = ~vs_prev & vSync;
    assign frame_edge = vfall & hfall;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        h_nxt           = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1;
        v_nxt           = v_cnt;
        state_nxt       = state;
        frame_start_nxt = 1'b0;
        code_nxt        = err_code;

        if (hfall) begin
            h_nxt = '0;
            if (vfall)
                v_nxt = '0;
            else if (v_cnt != CNT_MAX)
                v_nxt = v_cnt + 10'd1;
        end

        // Bit index equals the reported error code.
        err_vec[0] = hrise & (h_cnt != H_SYNC_LAST);
        err_vec[1] = hfall ? (h_cnt != H_LAST) : (h_cnt == H_LAST);
        err_vec[2] = ((vfall | vrise) & ~hfall) | (vrise & (v_cnt != V_SYNC_LAST));
        err_vec[3] = vfall ? (v_cnt != V_LAST) : (hfall & (v_cnt == V_LAST));
        err_any    = (state != SEARCH) && (err_vec != 4'b0000);

        case (state)
            SEARCH: begin
                if (frame_edge)
                    state_nxt = ACQUIRE;
            end
            ACQUIRE, LOCKED: begin
                if (err_any) begin
                    state_nxt = SEARCH;
                end else if (frame_edge) begin
                    state_nxt       = LOCKED;
                    frame_start_nxt = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase

        // Lowest code wins, so it is tested last.
        if (err_any) begin
            if (err_vec[3]) code_nxt = 2'd3;
            if (err_vec[2]) code_nxt = 2'd2;
            if (err_vec[1]) code_nxt = 2'd1;
            if (err_vec[0]) code_nxt = 2'd0;
        end

        locked_nxt = (state_nxt == LOCKED);
        de_nxt     = locked_nxt
                     && (h_nxt >= H_DE_FIRST) && (h_nxt < H_DE_END)
                     && (v_nxt >= V_DE_FIRST) && (v_nxt < V_DE_END);
        px_x_nxt   = de_nxt ? h_nxt - H_DE_FIRST : '0;
        px_y_nxt   = de_nxt ? v_nxt - V_DE_FIRST : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk25175KHz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEARCH;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            locked      <= 1'b0;
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_code    <= '0;
        end else begin
            state       <= state_nxt;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hs_prev     <= hSync;
            vs_prev     <= vSync;
            locked      <= locked_nxt;
            de          <= de_nxt;
            px_x        <= px_x_nxt;
            px_y        <= px_y_nxt;
            frame_start <= frame_start_nxt;
            sync_err    <= err_any;
            err_code    <= code_nxt;
        end
    end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Watches the active-low hSync/vSync pair (640x480@60, 800x525 totals) in the same clk25175KHz domain.
- Recovers pixel coordinates and checks every sync edge against nominal timing.
- Reports lock, display enable and sync errors; used as a loopback checker and as the front end of the capture path.

Parameters:
H_TOTAL, 800, clocks per line
H_SYNC, 96, hSync low width in clocks (low at hcount 0..H_SYNC-1)
H_BP, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vSync low width in lines (low at vcount 0..V_SYNC-1)
V_BP, 33, vertical back porch
V_ACTIVE, 480, visible lines

Ports:
clk25175KHz  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
hSync  in  1  horizontal sync, active low
vSync  in  1  vertical sync, active low
locked  out  1  timing verified for a full frame
de  out  1  display enable; visible pixel this cycle
px_x  out  10  visible column 0..H_ACTIVE-1; 0 when de=0
px_y  out  10  visible row 0..V_ACTIVE-1; 0 when de=0
frame_start  out  1  1-cycle pulse at each frame start while locked
sync_err  out  1  1-cycle pulse on a timing violation
err_code  out  2  cause of last error: 0 hSync width, 1 line period, 2 vSync width/alignment, 3 frame period; holds until next error

Behaviour:
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0; hs_prev=1, vs_prev=1; state=SEARCH.
  - All outputs 0.
- Edge detect, combinational on the registered previous samples:
  - hfall = hs_prev & ~hSync; hrise = ~hs_prev & hSync.
  - vfall and vrise are defined the same way on vSync.
- Horizontal counter: h_cnt <= hfall ? 0 : h_cnt+1 (saturate at 1023). h_cnt equals the transmitter hcount delayed 1 cycle (1-cycle latency).
- Vertical counter, updated only on hfall: v_cnt <= vfall ? 0 : v_cnt+1 (saturate at 1023).
- Checks are evaluated every cycle but flagged only in ACQUIRE/LOCKED:
  - E0: hrise with h_cnt != H_SYNC-1.
  - E1: hfall with h_cnt != H_TOTAL-1, or h_cnt == H_TOTAL-1 without hfall.
  - E2: vfall/vrise not coincident with hfall, or vrise with v_cnt != V_SYNC-1.
  - E3: vfall with v_cnt != V_TOTAL-1, or hfall with v_cnt == V_TOTAL-1 without vfall.
  - Simultaneous errors: lowest code wins.
- State machine:
  - SEARCH: counters free-run and resync on edges; no errors reported. vfall&hfall -> ACQUIRE.
  - ACQUIRE: any error -> sync_err pulse, err_code updated, go to SEARCH. Next vfall&hfall with no error -> LOCKED.
  - LOCKED: locked=1. Any error -> sync_err, err_code, locked=0 the next cycle, go to SEARCH.
  - frame_start pulses on every error-free vfall&hfall that leaves the state in LOCKED, including the ACQUIRE->LOCKED transition.
- Registered outputs, driven from the updated counters and valid the cycle after the corresponding sync edge/input:
  - de = locked & H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE & V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
  - px_x = h_cnt-(H_SYNC+H_BP); px_y = v_cnt-(V_SYNC+V_BP); both forced to 0 when de=0.
- First lock: exactly one full frame after the first frame start seen in SEARCH.
- Reset mid-frame: everything returns to reset values immediately. Relock takes at most 2 frames after the generator resumes.
- hSync held low after reset release: hs_prev=1 produces an hfall in the first cycle. This aligns with a generator that starts at hcount 0.

Test Plan:
- Nominal: generator model (800/96/525/2) released from reset together with the DUT -> locked rises 1 cycle after the vfall/hfall at cycle 420000 (second frame start, counting the first as cycle 0). sync_err never pulses over 3 frames. frame_start pulses every 420000 cycles.
- Pixel mapping while locked:
  - Transmitter (hcount,vcount)=(144,35) -> next cycle de=1, px=(0,0).
  - (783,514) -> px=(639,479).
  - (784,514) -> de=0, px=(0,0).
- hSync width: one line with hSync low for 95 cycles while locked -> sync_err with err_code=0, locked=0 the next cycle, relock after 2 clean frames.
- Line period: one line of 801 cycles -> err_code=1. Loss of hSync for 2 lines -> err_code=1 when h_cnt reaches 799.
- vSync width: vSync low 3 lines -> err_code=2. vSync falling at hcount 5 -> err_code=2.
- Frame period and reset: a 526-line frame -> err_code=3. Assert reset_n low mid-line for 3 cycles -> all outputs 0 asynchronously, relock within 2 frames.
